// File: rtl/poly_nco_pkg.sv
// poly_nco_pkg: shared types, tuning table and the saturation helper for the
// polyphonic NCO. Optional feature macro used by the slice:
// POLY_NCO_VOICE_STEAL_EN.
package poly_nco_pkg;

  localparam int KEY_W = 4;   // key index width, covers up to 16 keys
  localparam int AGE_W = 8;   // saturating per-voice age counter

  // 32-bit phase increments at 48 kHz, C4..D#5: round(f / 48000 * 2^32)
  localparam logic [31:0] KEY_INC [16] = '{
    32'd23409859, 32'd24801882, 32'd26276679, 32'd27839171,
    32'd29494574, 32'd31248413, 32'd33106541, 32'd35075158,
    32'd37160835, 32'd39370534, 32'd41711627, 32'd44191930,
    32'd46819719, 32'd49603764, 32'd52553357, 32'd55678343
  };

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_MUTE   = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Clamp a signed value into the range of a w-bit signed sample.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                             input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/poly_nco_if.sv
// poly_nco_if: key/sample-strobe inputs and mixed-sample outputs of poly_nco.
// master = upstream driver (debouncers / sample clock), slave = poly_nco.
interface poly_nco_if #(
  parameter int NUM_VOICES = 4,
  parameter int NUM_KEYS   = 12,
  parameter int SAMPLE_W   = 16
);
  logic                          sample_clk_en;
  logic [NUM_KEYS-1:0]           keys;
  logic [1:0]                    wave_sel;
  logic signed [SAMPLE_W-1:0]    sample_out;
  logic                          sample_valid;
  logic [$clog2(NUM_VOICES):0]   active_voices;
  logic                          overrun;

  modport master (
    output sample_clk_en, keys, wave_sel,
    input  sample_out, sample_valid, active_voices, overrun
  );

  modport slave (
    input  sample_clk_en, keys, wave_sel,
    output sample_out, sample_valid, active_voices, overrun
  );
endinterface

// File: rtl/poly_voice_alloc.sv
// poly_voice_alloc: key edge detect, pending press/release masks and the voice
// table. Owns all per-voice state; the sweep writes phase/age through the
// sweep_* port. Macro POLY_NCO_VOICE_STEAL_EN selects stealing the oldest
// voice when a press finds every voice busy; otherwise the press is dropped.
module poly_voice_alloc
  import poly_nco_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NUM_KEYS   = 12,
  parameter int PHASE_W    = 32
) (
  input  logic                                   master_clk,
  input  logic                                   rst_n,
  input  logic                                   alloc_en,
  input  logic [NUM_KEYS-1:0]                    keys,
  input  logic                                   sweep_we,
  input  logic [$clog2(NUM_VOICES)-1:0]          sweep_idx,
  input  logic [PHASE_W-1:0]                     sweep_phase,
  output logic [NUM_VOICES-1:0]                  voice_vld,
  output logic [NUM_VOICES-1:0][KEY_W-1:0]       voice_key,
  output logic [NUM_VOICES-1:0][PHASE_W-1:0]     voice_phase,
  output logic [$clog2(NUM_VOICES):0]            active_voices
);
  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int AV_W   = VIDX_W + 1;

  logic [NUM_KEYS-1:0]                keys_q, press_pend, rel_pend;
  logic [NUM_KEYS-1:0]                rise, fall, cancel;
  logic [NUM_KEYS-1:0]                serve_rel, serve_press, press_n, rel_n;
  logic [NUM_VOICES-1:0][AGE_W-1:0]   voice_age;
  logic                               rel_hit, press_hit, free_hit;
  logic                               rel_go, press_go;
  logic [KEY_W-1:0]                   rel_k, press_k;
  logic [VIDX_W-1:0]                  free_v, tgt_v;
  logic [AV_W-1:0]                    pop;
`ifdef POLY_NCO_VOICE_STEAL_EN
  logic [VIDX_W-1:0]                  steal_v;
`endif

  // Lowest pending release/press and lowest free voice (descending scans so
  // the lowest index is the last writer).
  always_comb begin
    rel_hit   = 1'b0;
    rel_k     = '0;
    press_hit = 1'b0;
    press_k   = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (rel_pend[k])   begin rel_hit   = 1'b1; rel_k   = KEY_W'(k); end
      if (press_pend[k]) begin press_hit = 1'b1; press_k = KEY_W'(k); end
    end
    free_hit = 1'b0;
    free_v   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_vld[v]) begin free_hit = 1'b1; free_v = VIDX_W'(v); end
    end
  end

`ifdef POLY_NCO_VOICE_STEAL_EN
  // Oldest voice, strict compare keeps the lowest index on ties.
  always_comb begin
    steal_v = '0;
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (voice_age[v] > voice_age[steal_v]) steal_v = VIDX_W'(v);
    end
  end
  assign tgt_v    = free_hit ? free_v : steal_v;
  assign press_go = alloc_en && !rel_hit && press_hit;
`else
  assign tgt_v    = free_v;
  assign press_go = alloc_en && !rel_hit && press_hit && free_hit;
`endif

  // Releases win over presses; a served press clears its pending bit even
  // when it finds no voice.
  assign rel_go      = alloc_en && rel_hit;
  assign serve_rel   = rel_go ? (NUM_KEYS'(1) << rel_k) : '0;
  assign serve_press = (alloc_en && !rel_hit && press_hit) ? (NUM_KEYS'(1) << press_k) : '0;

  // Edge detect and pending-mask update; release of a still-pending press
  // cancels both.
  assign rise    = keys & ~keys_q;
  assign fall    = ~keys & keys_q;
  assign cancel  = fall & press_pend & ~serve_press;
  assign press_n = ((press_pend & ~serve_press) | rise) & ~cancel;
  assign rel_n   = ((rel_pend & ~serve_rel) | fall) & ~cancel;

  // Popcount of allocated voices.
  always_comb begin
    pop = '0;
    for (int v = 0; v < NUM_VOICES; v++) pop = pop + AV_W'(voice_vld[v]);
  end

  // Voice table: sweep updates and allocator events are mutually exclusive.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q        <= '0;
      press_pend    <= '0;
      rel_pend      <= '0;
      voice_vld     <= '0;
      voice_key     <= '0;
      voice_phase   <= '0;
      voice_age     <= '0;
      active_voices <= '0;
    end else begin
      keys_q        <= keys;
      press_pend    <= press_n;
      rel_pend      <= rel_n;
      active_voices <= pop;
      if (sweep_we) begin
        voice_phase[sweep_idx] <= sweep_phase;
        if (voice_age[sweep_idx] != '1)
          voice_age[sweep_idx] <= voice_age[sweep_idx] + 1'b1;
      end else if (rel_go) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (voice_vld[v] && voice_key[v] == rel_k) voice_vld[v] <= 1'b0;
        end
      end else if (press_go) begin
        voice_vld[tgt_v]   <= 1'b1;
        voice_key[tgt_v]   <= press_k;
        voice_phase[tgt_v] <= '0;
        voice_age[tgt_v]   <= '0;
      end
    end
  end

endmodule

// File: rtl/poly_nco.sv
// poly_nco: time-multiplexed polyphonic NCO. One sample strobe sweeps every
// voice (one per clock), accumulates its waveform and emits one saturated
// mixed sample. Voice allocation lives in poly_voice_alloc; its optional
// stealing is controlled by POLY_NCO_VOICE_STEAL_EN.
module poly_nco
  import poly_nco_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NUM_KEYS   = 12,
  parameter int PHASE_W    = 32,
  parameter int SAMPLE_W   = 16,
  parameter int MIX_SHIFT  = 1
) (
  input logic       master_clk,
  input logic       rst_n,
  poly_nco_if.slave bus
);
  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W  = SAMPLE_W + VIDX_W;
  localparam logic [SAMPLE_W-1:0] WMAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  state_e                                state;
  logic [VIDX_W-1:0]                     v;
  logic signed [ACC_W-1:0]               acc, acc_sh, wave_ext;
  logic signed [63:0]                    acc_ext;
  logic [NUM_VOICES-1:0]                 voice_vld;
  logic [NUM_VOICES-1:0][KEY_W-1:0]      voice_key;
  logic [NUM_VOICES-1:0][PHASE_W-1:0]    voice_phase;
  logic [31:0]                           inc32;
  logic [PHASE_W-1:0]                    inc, new_phase;
  logic [SAMPLE_W-1:0]                   p;
  logic [SAMPLE_W-2:0]                   tri_u;
  logic signed [SAMPLE_W-1:0]            wave;
  logic                                  alloc_en, sweep_we;

  // Allocator only runs in IDLE without a strobe, so a press that coincides
  // with a strobe lands after the sweep it would otherwise corrupt.
  assign alloc_en    = (state == ST_IDLE) && !bus.sample_clk_en;
  assign sweep_we    = (state == ST_SWEEP) && voice_vld[v];
  assign bus.overrun = bus.sample_clk_en && (state != ST_IDLE);

  poly_voice_alloc #(
    .NUM_VOICES (NUM_VOICES),
    .NUM_KEYS   (NUM_KEYS),
    .PHASE_W    (PHASE_W)
  ) u_alloc (
    .master_clk    (master_clk),
    .rst_n         (rst_n),
    .alloc_en      (alloc_en),
    .keys          (bus.keys),
    .sweep_we      (sweep_we),
    .sweep_idx     (v),
    .sweep_phase   (new_phase),
    .voice_vld     (voice_vld),
    .voice_key     (voice_key),
    .voice_phase   (voice_phase),
    .active_voices (bus.active_voices)
  );

  // Table entries are 32-bit; rescale to the accumulator width.
  assign inc32 = KEY_INC[voice_key[v]];
  generate
    if (PHASE_W == 32) begin : g_inc_eq
      assign inc = inc32;
    end else if (PHASE_W > 32) begin : g_inc_wide
      assign inc = {inc32, {(PHASE_W-32){1'b0}}};
    end else begin : g_inc_narrow
      assign inc = inc32[31 -: PHASE_W];
    end
  endgenerate

  assign new_phase = voice_phase[v] + inc;
  assign p         = new_phase[PHASE_W-1 -: SAMPLE_W];
  // Triangle fold: rising over the lower half, mirrored over the upper half.
  assign tri_u     = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];

  // Waveform of the voice being swept, from its freshly advanced phase.
  always_comb begin
    wave = '0;
    case (wave_e'(bus.wave_sel))
      WAVE_SAW:    wave = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
      WAVE_SQUARE: wave = p[SAMPLE_W-1] ? -WMAX : WMAX;
      WAVE_TRI:    wave = {tri_u, 1'b0} - WMAX;
      default:     wave = '0;
    endcase
  end

  assign wave_ext = {{VIDX_W{wave[SAMPLE_W-1]}}, wave};
  assign acc_sh   = acc >>> MIX_SHIFT;
  assign acc_ext  = {{(64-ACC_W){acc_sh[ACC_W-1]}}, acc_sh};

  // Sweep FSM with registered sample outputs.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      v                <= '0;
      acc              <= '0;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.sample_clk_en) begin
            state <= ST_SWEEP;
            v     <= '0;
            acc   <= '0;
          end
        end
        ST_SWEEP: begin
          if (voice_vld[v]) acc <= acc + wave_ext;
          if (v == VIDX_W'(NUM_VOICES - 1)) state <= ST_OUT;
          else                              v     <= v + 1'b1;
        end
        ST_OUT: begin
          bus.sample_out   <= SAMPLE_W'(sat(acc_ext, SAMPLE_W));
          bus.sample_valid <= 1'b1;
          state            <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_nco.sv
// tb_poly_nco: directed stimulus with a scoreboard. Each issued strobe pushes
// its expected sample and expected valid cycle; a negedge monitor pops and
// compares whenever sample_valid is seen.
module tb_poly_nco;
  localparam int NV = 4;
  localparam int NK = 12;
  localparam int SW = 16;

`ifdef POLY_NCO_VOICE_STEAL_EN
  localparam int AV_AFTER_REL0   = 4;
  localparam int AV_AFTER_REL123 = 1;
  localparam int SAW_STOLEN      = -32318;  // voice 0 now key 4: 29494574>>16 = 450
`else
  localparam int AV_AFTER_REL0   = 3;
  localparam int AV_AFTER_REL123 = 0;
  localparam int SAW_STOLEN      = 0;       // key 4 was never given a voice
`endif

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  poly_nco_if #(.NUM_VOICES(NV), .NUM_KEYS(NK), .SAMPLE_W(SW)) bus ();

  poly_nco #(
    .NUM_VOICES (NV),
    .NUM_KEYS   (NK),
    .PHASE_W    (32),
    .SAMPLE_W   (SW),
    .MIX_SHIFT  (0)
  ) dut (
    .master_clk (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One strobe; the result must appear NV+1 cycles after it is sampled.
  task automatic sample(input int exp);
    bus.sample_clk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_clk_en = 1'b0;
    sb.push_back('{exp, cyc + NV + 1});
    step(NV + 2);
    chk("drain", sb.size(), 0);
  endtask

  // Monitor: every sample_valid must match the oldest outstanding strobe.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.sample_valid) begin
      chk("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sample", bus.sample_out, e.val);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    bus.sample_clk_en = 1'b0;
    bus.keys          = '0;
    bus.wave_sel      = 2'd0;
    rst_n             = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sample_out", bus.sample_out, 0);
    chk("rst_sample_valid", bus.sample_valid, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_active", bus.active_voices, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);

    // Silence with no keys
    sample(0);
    sample(0);

    // Key 9 (inc 39370534), single voice, wave changes between samples
    bus.keys[9] = 1'b1;
    step(4);
    chk("active_k9", bus.active_voices, 1);
    sample(-32168);                 // 39370534>>16 = 600
    sample(-31567);                 // 78741068>>16 = 1201
    bus.wave_sel = 2'd1;
    sample(32767);                  // 118111602>>16 = 1802, MSB clear
    bus.wave_sel = 2'd2;
    sample(-27963);                 // 157482136>>16 = 2402 -> 2*2402-32767
    bus.wave_sel = 2'd3;
    sample(0);
    bus.keys[9] = 1'b0;
    step(4);
    chk("active_rel9", bus.active_voices, 0);
    bus.wave_sel = 2'd0;
    sample(0);

    // Keys 0..3 on successive cycles, square: 4*32767 clamps
    for (int k = 0; k < 4; k++) begin
      bus.keys[k] = 1'b1;
      step(1);
    end
    step(6);
    chk("active_k0_3", bus.active_voices, 4);
    bus.wave_sel = 2'd1;
    sample(32767);

    // Fifth key with all voices busy
    bus.keys[4] = 1'b1;
    step(4);
    chk("active_k4", bus.active_voices, 4);
    bus.keys[0] = 1'b0;
    step(4);
    chk("active_rel0", bus.active_voices, AV_AFTER_REL0);
    bus.keys[3:1] = 3'b000;
    step(8);
    chk("active_rel123", bus.active_voices, AV_AFTER_REL123);
    bus.wave_sel = 2'd0;
    sample(SAW_STOLEN);
    bus.keys[4] = 1'b0;
    step(4);
    chk("active_rel4", bus.active_voices, 0);
    bus.keys[4] = 1'b1;
    step(4);
    chk("active_repress4", bus.active_voices, 1);
    sample(-32318);                 // fresh voice: 29494574>>16 = 450
    bus.keys = '0;
    step(4);
    chk("active_all_off", bus.active_voices, 0);

    // Strobes 2 cycles apart: second is dropped with overrun
    bus.sample_clk_en = 1'b1;
    @(negedge clk);
    chk("overrun_idle", bus.overrun, 0);
    @(posedge clk);
    #1;
    bus.sample_clk_en = 1'b0;
    sb.push_back('{0, cyc + NV + 1});
    step(1);
    bus.sample_clk_en = 1'b1;
    @(negedge clk);
    chk("overrun_sweep", bus.overrun, 1);
    @(posedge clk);
    #1;
    bus.sample_clk_en = 1'b0;
    step(NV + 2);
    chk("drain_overrun", sb.size(), 0);

    // Reset in the middle of a sweep
    bus.keys[9] = 1'b1;
    step(4);
    sample(-32168);
    bus.sample_clk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_clk_en = 1'b0;
    step(2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_sample_out", bus.sample_out, 0);
    chk("midrst_sample_valid", bus.sample_valid, 0);
    chk("midrst_active", bus.active_voices, 0);
    step(2);
    rst_n = 1'b1;
    step(NV + 4);
    chk("drain_midrst", sb.size(), 0);
    chk("active_after_rst", bus.active_voices, 1);  // held key seen as a press
    sample(-32168);
    bus.keys = '0;
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
